multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath select, including the immediate-extender mode (sign, zero or upper), so a single extender serves all I-type instructions.
- Sits beside the datapath. Takes the opcode from the instruction register and a memory ready handshake.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_next_state.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Optional macro MULTICYCLE_ILLEGAL_TRAP_EN adds the HALT state.
package mc_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_WB_I     = 4'd9,
    ST_JUMP     = 4'd10,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ST_HALT     = 4'd11,
`endif
    ST_BRANCH   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state decoder for the multi-cycle control FSM.
// Illegal opcodes trap to HALT when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
module mc_next_state
  import mc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_t          state_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
  output state_t          next_o
);

  always_comb begin
    next_o = ST_FETCH;
    case (state_i)
      ST_FETCH:    next_o = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op_i)
          OP_LW, OP_SW:                          next_o = ST_MEM_ADDR;
          OP_RTYPE:                              next_o = ST_EXEC_R;
          OP_BEQ, OP_BNE:                        next_o = ST_BRANCH;
          OP_J:                                  next_o = ST_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
          OP_LUI:                                next_o = ST_EXEC_I;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:                               next_o = ST_HALT;
`else
          default:                               next_o = ST_FETCH;
`endif
        endcase
      end
      ST_MEM_ADDR: next_o = (op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   next_o = mem_ready_i ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WR:   next_o = mem_ready_i ? ST_FETCH : ST_MEM_WR;
      ST_EXEC_R:   next_o = ST_WB_R;
      ST_EXEC_I:   next_o = ST_WB_I;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      ST_HALT:     next_o = ST_HALT;
`endif
      default:     next_o = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU; outputs decode from state.
// MULTICYCLE_ILLEGAL_TRAP_EN adds HALT and the illegal_o port.
//
// state    | meaning
// FETCH    | read instruction, PC += 4 when memory ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read, wait for ready
// MEM_WB   | MDR -> rt
// MEM_WR   | data write, wait for ready
// EXEC_R   | R-type ALU operation
// WB_R     | ALUOut -> rd
// EXEC_I   | immediate ALU operation
// WB_I     | ALUOut -> rt
// BRANCH   | beq/bne compare and conditional PC load
// JUMP     | PC <- jump target
// HALT     | illegal opcode trap, exit only by reset
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               branch_ne_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               mem_to_reg_o,
  output logic               reg_dst_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [2:0]         alu_op_o,
  output logic [1:0]         pc_src_o,
  output logic [1:0]         ext_mode_o,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  output logic               illegal_o,
`endif
  output logic [STATE_W-1:0] state_o
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_imm_alu;
  logic [1:0] w_imm_ext;

  mc_next_state #(.OP_W(OP_W)) u_next (
    .state_i     (r_state),
    .op_i        (op_i),
    .mem_ready_i (mem_ready_i),
    .next_o      (w_next)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  // Immediate ALU op and extender mode, shared by EXEC_I and WB_I.
  always_comb begin
    w_imm_alu = ALU_ADD;
    w_imm_ext = EXT_SIGN;
    case (op_i)
      OP_SLTI: w_imm_alu = ALU_SLT;
      OP_ANDI: begin w_imm_alu = ALU_AND; w_imm_ext = EXT_ZERO;  end
      OP_ORI:  begin w_imm_alu = ALU_OR;  w_imm_ext = EXT_ZERO;  end
      OP_LUI:  begin w_imm_alu = ALU_OR;  w_imm_ext = EXT_UPPER; end
      default: ;
    endcase
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_B;
    alu_op_o        = ALU_ADD;
    pc_src_o        = PCSRC_ALU;
    ext_mode_o      = EXT_SIGN;
    case (r_state)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        alu_src_b_o = SRCB_FOUR;
      end
      ST_DECODE:   alu_src_b_o = SRCB_IMM_SH;
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      ST_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = w_imm_alu;
        ext_mode_o  = w_imm_ext;
      end
      ST_WB_I: begin
        reg_write_o = 1'b1;
        ext_mode_o  = w_imm_ext;
      end
      ST_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_src_o        = PCSRC_ALUOUT;
        branch_ne_o     = (op_i == OP_BNE);
      end
      ST_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_o = (r_state == ST_HALT);
`endif
  assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences, scoreboard queue.
// Builds with or without MULTICYCLE_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MADDR = 4'd2, S_MRD  = 4'd3;
  localparam logic [3:0] S_MWB   = 4'd4,  S_MWR    = 4'd5,  S_EXR   = 4'd6, S_WBR  = 4'd7;
  localparam logic [3:0] S_EXI   = 4'd8,  S_WBI    = 4'd9,  S_JUMP  = 4'd10, S_HALT = 4'd11;
  localparam logic [3:0] S_BR    = 4'd12;

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rwr, sa;
    logic [1:0] sb;
    logic [2:0] aluop;
    logic [1:0] pcs;
    logic [1:0] ext;
  } outs_t;

  typedef struct {
    string      tag;
    logic [3:0] st;
    outs_t      o;
    logic       ill;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o, mem_write_o;
  logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o, ext_mode_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       illegal_obs;
  outs_t      obs;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .op_i            (op_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .branch_ne_o     (branch_ne_o),
    .iord_o          (iord_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_dst_o       (reg_dst_o),
    .reg_write_o     (reg_write_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_src_o        (pc_src_o),
    .ext_mode_o      (ext_mode_o),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    .illegal_o       (illegal_obs),
`endif
    .state_o         (state_o)
  );

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_obs = 1'b0;
`endif

  assign obs = {pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o, mem_write_o,
                ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
                alu_src_b_o, alu_op_o, pc_src_o, ext_mode_o};

  // Expected output word for a state, written out from the control table.
  function automatic outs_t exp_outs(logic [3:0] st, logic [5:0] op, logic rdy);
    outs_t o;
    o = '0;
    case (st)
      S_FETCH:  begin o.mrd = 1; o.sb = 2'b01; o.irw = rdy; o.pcw = rdy; end
      S_DECODE: o.sb = 2'b11;
      S_MADDR:  begin o.sa = 1; o.sb = 2'b10; end
      S_MRD:    begin o.mrd = 1; o.iord = 1; end
      S_MWB:    begin o.rwr = 1; o.m2r = 1; end
      S_MWR:    begin o.mwr = 1; o.iord = 1; end
      S_EXR:    begin o.sa = 1; o.aluop = 3'b010; end
      S_WBR:    begin o.rwr = 1; o.rdst = 1; end
      S_EXI, S_WBI: begin
        if (st == S_EXI) begin o.sa = 1; o.sb = 2'b10; end
        else o.rwr = 1;
        case (op)
          6'b001010: if (st == S_EXI) o.aluop = 3'b011;
          6'b001100: begin if (st == S_EXI) o.aluop = 3'b100; o.ext = 2'b01; end
          6'b001101: begin if (st == S_EXI) o.aluop = 3'b101; o.ext = 2'b01; end
          6'b001111: begin if (st == S_EXI) o.aluop = 3'b101; o.ext = 2'b10; end
          default: ;
        endcase
      end
      S_BR:     begin o.sa = 1; o.aluop = 3'b001; o.pcwc = 1; o.pcs = 2'b01;
                      o.bne = (op == 6'b000101); end
      S_JUMP:   begin o.pcw = 1; o.pcs = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic check_one(string tag, logic got, logic want);
    n_cmp++;
    assert (got === want) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic pop_and_compare();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_mis++;
      $error("FAIL scoreboard: queue empty, observed state %0d", state_o);
      return;
    end
    e = q.pop_front();
    n_cmp++;
    assert (state_o === e.st) else begin
      n_mis++;
      $error("FAIL %s.state: observed %0d expected %0d", e.tag, state_o, e.st);
    end
    n_cmp++;
    assert (obs === e.o) else begin
      n_mis++;
      $error("FAIL %s.outs: observed %05h expected %05h", e.tag, obs, e.o);
    end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    check_one({e.tag, ".illegal"}, illegal_obs, e.ill);
`endif
  endtask

  // One clock: drive inputs, push expectation, compare at negedge, advance past posedge.
  task automatic step(string tag, logic [3:0] st, logic [5:0] op, logic rdy);
    exp_t e;
    op_i = op;
    mem_ready_i = rdy;
    e.tag = tag; e.st = st; e.o = exp_outs(st, op, rdy); e.ill = (st == S_HALT);
    q.push_back(e);
    @(negedge clk_i);
    pop_and_compare();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_i(string tag, logic [5:0] op);
    step({tag, ".f"}, S_FETCH, op, 1'b1);
    step({tag, ".d"}, S_DECODE, op, 1'b1);
    step({tag, ".x"}, S_EXI, op, 1'b1);
    step({tag, ".w"}, S_WBI, op, 1'b1);
  endtask

  task automatic async_reset_pulse(string tag);
    mem_ready_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check_one({tag, ".state_fetch"}, (state_o == S_FETCH), 1'b1);
    check_one({tag, ".mem_read"}, mem_read_o, 1'b1);
    check_one({tag, ".iord"}, iord_o, 1'b0);
    check_one({tag, ".reg_write"}, reg_write_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    op_i = 6'b000000;
    mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    step("reset", S_FETCH, 6'b000000, 1'b0);
    rst_i = 1'b1;

    // lw, zero wait states: 5 cycles
    step("lw.f",  S_FETCH,  6'b100011, 1'b1);
    step("lw.d",  S_DECODE, 6'b100011, 1'b1);
    step("lw.a",  S_MADDR,  6'b100011, 1'b1);
    step("lw.r",  S_MRD,    6'b100011, 1'b1);
    step("lw.wb", S_MWB,    6'b100011, 1'b1);

    // Fetch stalled 3 cycles, then R-type
    for (int i = 0; i < 3; i++) step("fwait", S_FETCH, 6'b000000, 1'b0);
    step("rt.f", S_FETCH,  6'b000000, 1'b1);
    step("rt.d", S_DECODE, 6'b000000, 1'b1);
    step("rt.x", S_EXR,    6'b000000, 1'b1);
    step("rt.w", S_WBR,    6'b000000, 1'b1);

    // sw with one wait cycle in MEM_WR
    step("sw.f",  S_FETCH,  6'b101011, 1'b1);
    step("sw.d",  S_DECODE, 6'b101011, 1'b1);
    step("sw.a",  S_MADDR,  6'b101011, 1'b1);
    step("sw.w0", S_MWR,    6'b101011, 1'b0);
    step("sw.w1", S_MWR,    6'b101011, 1'b1);

    run_i("andi", 6'b001100);
    run_i("lui",  6'b001111);
    run_i("addi", 6'b001000);
    run_i("slti", 6'b001010);
    run_i("ori",  6'b001101);

    step("bne.f", S_FETCH,  6'b000101, 1'b1);
    step("bne.d", S_DECODE, 6'b000101, 1'b1);
    step("bne.b", S_BR,     6'b000101, 1'b1);
    step("beq.f", S_FETCH,  6'b000100, 1'b1);
    step("beq.d", S_DECODE, 6'b000100, 1'b1);
    step("beq.b", S_BR,     6'b000100, 1'b1);
    step("j.f",   S_FETCH,  6'b000010, 1'b1);
    step("j.d",   S_DECODE, 6'b000010, 1'b1);
    step("j.j",   S_JUMP,   6'b000010, 1'b1);

    // Reset while lw is waiting in MEM_RD: no writeback afterwards
    step("lwr.f", S_FETCH,  6'b100011, 1'b1);
    step("lwr.d", S_DECODE, 6'b100011, 1'b1);
    step("lwr.a", S_MADDR,  6'b100011, 1'b1);
    step("lwr.r", S_MRD,    6'b100011, 1'b0);
    async_reset_pulse("rst_mid");
    step("post_rst", S_FETCH, 6'b100011, 1'b0);

    step("ill.f", S_FETCH,  6'b111111, 1'b1);
    step("ill.d", S_DECODE, 6'b111111, 1'b1);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step("halt", S_HALT, 6'b000000, 1'b1);
    async_reset_pulse("rst_halt");
    step("after_halt", S_FETCH, 6'b000000, 1'b0);
`else
    step("ill.nop", S_FETCH, 6'b111111, 1'b1);
`endif

    if (q.size() != 0) begin
      n_cmp++; n_mis++;
      $error("FAIL scoreboard: %0d entries left", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
